// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the branch resolve controller: ALU op codes, branch
// opcode/funct3 values, controller state and the ALU control bundle.
package branch_resolve_ctrl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

  typedef struct packed {
    logic       ainvert;
    logic       binvert;
    logic       cin;
    logic [1:0] op;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_IDLE = '{ainvert: 1'b0, binvert: 1'b0, cin: 1'b0, op: OP_AND};
  // a + ~b + 1 == a - b
  localparam alu_ctrl_t ALU_SUB  = '{ainvert: 1'b0, binvert: 1'b1, cin: 1'b1, op: OP_ADD};

  function automatic logic is_branch(input logic [31:0] instr);
    return instr[6:0] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_imm.sv
// SB-format immediate extractor: gathers the scattered offset bits and
// sign-extends the 13-bit byte offset to N bits.
module sb_imm_gen #(
  parameter int N = 64
) (
  input  logic [31:0]  instr,
  output logic [N-1:0] imm
);

  logic [12:0] raw;
  logic        unused_fields;

  assign raw           = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm           = {{(N-13){raw[12]}}, raw};
  assign unused_fields = ^{instr[24:12], instr[6:0]};

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves BEQ/BNE by driving an external combinational ALU as a subtractor
// and committing either the branch target or the sequential PC.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] PC_INC   = N'(4)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_ainvert,
  output logic         alu_binvert,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  input  logic         alu_zero,
  output logic [N-1:0] pc,
  output logic         pc_valid,
  output logic         taken
);

  state_t      state;
  alu_ctrl_t   ctrl;
  logic [31:0] instr_q;
  logic        cond_q;
  logic        cond;
  logic [N-1:0] imm;

  sb_imm_gen #(.N(N)) u_imm (
    .instr (instr_q),
    .imm   (imm)
  );

  always_comb begin
    cond = 1'b0;
    if (is_branch(instr_q)) begin
      if (instr_q[14:12] == F3_BEQ)      cond = alu_zero;
      else if (instr_q[14:12] == F3_BNE) cond = ~alu_zero;
    end
  end

  assign alu_ainvert = ctrl.ainvert;
  assign alu_binvert = ctrl.binvert;
  assign alu_cin     = ctrl.cin;
  assign alu_op      = ctrl.op;

  // alu_a/alu_b double as the latched operands: loaded on accept, held
  // through EXEC, then returned to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      taken       <= 1'b0;
      instr_ready <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      ctrl        <= ALU_IDLE;
      instr_q     <= '0;
      cond_q      <= 1'b0;
    end else begin
      pc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            alu_a       <= rs1_data;
            alu_b       <= rs2_data;
            ctrl        <= is_branch(instr) ? ALU_SUB : ALU_IDLE;
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          cond_q <= cond;
          alu_a  <= '0;
          alu_b  <= '0;
          ctrl   <= ALU_IDLE;
          state  <= COMMIT;
        end
        COMMIT: begin
          pc          <= cond_q ? pc + imm : pc + PC_INC;
          pc_valid    <= 1'b1;
          taken       <= cond_q;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl with a behavioural ALU and a
// PC reference model driven by directed and randomized branches.
module tb_branch_resolve_ctrl;

  localparam int          N        = 64;
  localparam logic [N-1:0] RESET_PC = 64'h100;
  localparam logic [6:0]  BR       = 7'b1100011;

  logic         clk = 1'b0;
  logic         reset;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [N-1:0] rs1_data, rs2_data;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_ainvert, alu_binvert, alu_cin;
  logic [1:0]   alu_op;
  logic         alu_zero;
  logic [N-1:0] pc;
  logic         pc_valid;
  logic         taken;

  branch_resolve_ctrl #(.N(N), .RESET_PC(RESET_PC), .PC_INC(64'd4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert), .alu_binvert(alu_binvert),
    .alu_cin(alu_cin), .alu_op(alu_op), .alu_zero(alu_zero),
    .pc(pc), .pc_valid(pc_valid), .taken(taken)
  );

  always #5 clk = ~clk;

  // Behavioural n-bit ALU
  logic [N-1:0] ua, ub, res;
  always_comb begin
    ua = alu_ainvert ? ~alu_a : alu_a;
    ub = alu_binvert ? ~alu_b : alu_b;
    case (alu_op)
      2'b00:   res = ua & ub;
      2'b01:   res = ua | ub;
      default: res = ua + ub + N'(alu_cin);
    endcase
  end
  assign alu_zero = (res == '0);

  typedef struct { logic [N-1:0] pc; logic tk; } pc_exp_t;
  typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic [4:0] ctl; } alu_exp_t;
  pc_exp_t  pc_q[$];
  alu_exp_t alu_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, phase = 0;
  logic vexp = 1'b0, rst_d = 1'b0, last_taken = 1'b0, started = 1'b0;
  logic [N-1:0] ref_pc;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sb(input logic [6:0] opc, input logic [2:0] f3, input int imm);
    logic [12:0] m;
    m = imm[12:0];
    return {m[12], m[10:5], 5'd2, 5'd1, f3, m[4:1], m[11], opc};
  endfunction

  // Reference: branch outcome from operand comparison, target from the SB offset
  task automatic model(input logic [31:0] i, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [12:0] im;
    logic        br, tk;
    longint      off;
    im  = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    off = longint'($signed(im));
    br  = (i[6:0] == BR);
    tk  = br && ((i[14:12] == 3'd0 && a == b) || (i[14:12] == 3'd1 && a != b));
    ref_pc = tk ? ref_pc + 64'(off) : ref_pc + 64'd4;
    pc_q.push_back('{pc: ref_pc, tk: tk});
    alu_q.push_back('{a: a, b: b, ctl: br ? 5'b01110 : 5'b00000});
  endtask

  task automatic send(input logic [31:0] i, input logic [N-1:0] a, input logic [N-1:0] b,
                      output int acc_cyc);
    int w = 0;
    instr = i; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    acc_cyc = -1;
    if (!instr_ready) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_timeout: instr_ready stayed %b, required 1", instr_ready);
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    model(i, a, b);
    #1;
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
  endtask

  task automatic settle(input logic [N-1:0] exp_pc, input logic exp_tk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pc_directed", pc, exp_pc);
    chk("taken_directed", N'(taken), N'(exp_tk));
  endtask

  task automatic do_reset(input int cycles, input logic hold_valid);
    reset = 1'b1;
    instr_valid = hold_valid;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    instr_valid = 1'b0;
    ref_pc = RESET_PC;
    pc_q.delete();
  endtask

  // Monitor: track handshake phase independently of the DUT's state register
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
    if (reset) begin
      phase <= 0;
      vexp  <= 1'b0;
    end else begin
      vexp <= (phase == 2);
      if (instr_valid && instr_ready) phase <= 1;
      else if (phase == 1)            phase <= 2;
      else if (phase == 2)            phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      alu_exp_t ea;
      pc_exp_t  ep;
      if (rst_d) last_taken = 1'b0;
      chk("instr_ready", N'(instr_ready), N'(phase == 0));
      if (phase == 1 && alu_q.size() > 0) begin
        ea = alu_q.pop_front();
        chk("alu_a_exec", alu_a, ea.a);
        chk("alu_b_exec", alu_b, ea.b);
        chk("alu_ctl_exec", N'({alu_ainvert, alu_binvert, alu_cin, alu_op}), N'(ea.ctl));
      end else begin
        chk("alu_a_idle", alu_a, '0);
        chk("alu_b_idle", alu_b, '0);
        chk("alu_ctl_idle", N'({alu_ainvert, alu_binvert, alu_cin, alu_op}), '0);
      end
      chk("pc_valid", N'(pc_valid), N'(vexp));
      if (pc_valid) begin
        if (pc_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pc_valid: pc %h with no pending instruction", pc);
        end else begin
          ep = pc_q.pop_front();
          chk("pc_commit", pc, ep.pc);
          chk("taken_commit", N'(taken), N'(ep.tk));
          last_taken = ep.tk;
        end
      end else begin
        chk("taken_hold", N'(taken), N'(last_taken));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [N-1:0] ra, rb;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    ref_pc = RESET_PC;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_pc", pc, RESET_PC);
    chk("reset_pc_valid", N'(pc_valid), '0);
    chk("reset_taken", N'(taken), '0);
    chk("reset_ready", N'(instr_ready), 1);

    send(sb(BR, 3'd0, 16), 5, 5, a0);               settle(64'h110, 1'b1);
    @(posedge clk); #1; do_reset(1, 1'b0);
    @(negedge clk); chk("pc_after_reset", pc, RESET_PC);
    send(sb(BR, 3'd0, 16), 5, 6, a0);               settle(64'h104, 1'b0);
    send(sb(BR, 3'd0, 252), 7, 7, a0);              settle(64'h200, 1'b1);
    send(sb(BR, 3'd1, -8), 1, 2, a0);               settle(64'h1F8, 1'b1);
    send(sb(BR, 3'd0, 8), 3, 3, a0);                settle(64'h200, 1'b1);
    send(sb(BR, 3'd1, -8), 9, 9, a0);               settle(64'h204, 1'b0);
    send(sb(BR, 3'd0, -520), 0, 0, a0);             settle(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    send(sb(7'b0110011, 3'd0, 16), 1, 1, a0);       settle(64'h0, 1'b0);
    send(sb(BR, 3'd0, 0), 42, 42, a0);              settle(64'h0, 1'b1);
    send(sb(BR, 3'd4, 64), 42, 42, a0);             settle(64'h4, 1'b0);

    // Abort in EXEC; second reset cycle overlaps a valid handshake in IDLE
    send(sb(BR, 3'd0, 32), 8, 8, a0);
    do_reset(2, 1'b1);
    @(negedge clk);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_pc_valid", N'(pc_valid), '0);
    chk("abort_ready", N'(instr_ready), 1);

    // instr_valid held high: back-to-back acceptances
    a1 = -1;
    for (int k = 0; k < 24; k++) begin
      opc = ($urandom_range(3) != 0) ? BR : 7'($urandom);
      f3  = ($urandom_range(3) == 0) ? 3'($urandom) : 3'($urandom_range(1));
      ra  = {$urandom, $urandom};
      rb  = $urandom_range(1) ? ra : {$urandom, $urandom};
      send(sb(opc, f3, int'($urandom_range(8191))), ra, rb, a0);
      if (a1 >= 0 && a0 >= 0) chk("accept_spacing", N'(a0 - a1), 3);
      a1 = a0;
    end

    // Random traffic with idle gaps
    for (int k = 0; k < 40; k++) begin
      instr_valid = 1'b0;
      repeat ($urandom_range(3)) @(negedge clk);
      opc = ($urandom_range(3) != 0) ? BR : 7'($urandom);
      f3  = 3'($urandom_range(2));
      ra  = 64'($urandom_range(3));
      rb  = 64'($urandom_range(3));
      send(sb(opc, f3, int'($urandom_range(8191))), ra, rb, a0);
    end

    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", N'(pc_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
